// File: rtl/hdmi_pixel_feeder.sv
// hdmi_pixel_feeder
// Buffers an incoming pixel stream in a small FIFO, generates the video
// timing for the HDMI path and releases pixels in lockstep with the active
// area. Frame alignment is recovered from the start-of-frame marker carried
// with the first pixel of every frame. All outputs towards the TMDS encoders
// are registered, one cycle behind the timing counters.
//
// Handshake: a pixel is transferred on every rising clk edge where
// s_valid && s_ready are both high. s_ready depends only on registered FIFO
// occupancy, never on s_valid. The source must hold s_data/s_sof stable
// while s_valid is high and s_ready is low. s_ready is low during reset and
// rises on the first clock edge after reset is released.

module hdmi_pixel_feeder #(
   parameter int          H_ACTIVE     = 1280,
   parameter int          H_TOTAL      = 1650,
   parameter int          H_SYNC_START = 1390,
   parameter int          H_SYNC_END   = 1430,
   parameter int          V_ACTIVE     = 720,
   parameter int          V_TOTAL      = 750,
   parameter int          V_SYNC_START = 725,
   parameter int          V_SYNC_END   = 730,
   parameter int          FIFO_AW      = 4,
   parameter logic [23:0] BLANK_RGB    = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] s_data,
   input  logic        s_sof,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        draw_area,
   output logic        hsync,
   output logic        vsync,
   output logic        underflow,
   output logic        frame_start,
   output logic [1:0]  dbg_state
);

   localparam int HW    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VW    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;

   // SEEK: discard until a sof pixel heads the FIFO.
   // WAIT: hold the sof pixel until the frame wraps to (0,0).
   // RUN : release one pixel per active position.
   typedef enum logic [1:0] {
      ST_SEEK = 2'd0,
      ST_WAIT = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Timing counters
   // ------------------------------------------------------------------
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          h_last;
   logic          v_last;
   logic          frame_last;
   logic          at_origin;
   logic          act;
   logic          hsync_d;
   logic          vsync_d;

   assign h_last     = (h_cnt_q == HW'(H_TOTAL - 1));
   assign v_last     = (v_cnt_q == VW'(V_TOTAL - 1));
   assign frame_last = h_last && v_last;
   assign at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign act        = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
   assign hsync_d    = (h_cnt_q >= HW'(H_SYNC_START)) && (h_cnt_q < HW'(H_SYNC_END));
   assign vsync_d    = (v_cnt_q >= VW'(V_SYNC_START)) && (v_cnt_q < VW'(V_SYNC_END));

   // Next counter position: h wraps every line, v advances on each h wrap.
   always_comb begin
      h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_last) begin
         v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      end
   end

   // Counter registers; timing free-runs in every FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Pixel FIFO, entries are {sof, r, g, b}
   // ------------------------------------------------------------------
   logic [24:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q;
   logic [FIFO_AW-1:0] rd_ptr_q;
   logic [CW-1:0]      count_q, count_d;
   logic               s_ready_q;
   logic               push;
   logic               pop;
   logic               empty;
   logic [24:0]        head;
   logic               head_sof;
   logic [23:0]        head_rgb;

   // Acceptance is gated by the registered ready only, so a pop in the same
   // cycle never lets a push into a full FIFO.
   assign push     = s_valid && s_ready_q;
   assign empty    = (count_q == '0);
   assign head     = mem_q[rd_ptr_q];
   assign head_sof = head[24];
   assign head_rgb = head[23:0];
   assign s_ready  = s_ready_q;

   // Occupancy update; simultaneous push and pop cancel out.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents are qualified by the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {s_sof, s_data};
      end
   end

   // Pointers, occupancy and the registered ready flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         s_ready_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         end
         count_q   <= count_d;
         s_ready_q <= (count_d != CW'(DEPTH));
      end
   end

   // ------------------------------------------------------------------
   // Alignment state machine
   // ------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [23:0] rgb_d;
   logic        underflow_d;
   logic        frame_start_d;

   assign dbg_state = state_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_SEEK;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decision from FIFO head and counter position.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SEEK: begin
            if (!empty && head_sof) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Leave on the last position so RUN starts exactly at (0,0).
            if (frame_last) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (act) begin
               if (empty) begin
                  state_d = ST_SEEK;
               end else if (!head_sof && at_origin) begin
                  // Previous frame was longer than the active area.
                  state_d = ST_SEEK;
               end else if (head_sof && !at_origin) begin
                  // Next frame arrived early; keep its sof pixel for later.
                  state_d = ST_WAIT;
               end
            end
         end
         default: state_d = ST_SEEK;
      endcase
   end

   // Pop control and pixel selection for the coming output cycle.
   always_comb begin
      pop           = 1'b0;
      rgb_d         = BLANK_RGB;
      underflow_d   = 1'b0;
      frame_start_d = 1'b0;
      case (state_q)
         ST_SEEK: begin
            if (!empty && !head_sof) begin
               pop = 1'b1;
            end
         end
         ST_RUN: begin
            if (act) begin
               if (empty) begin
                  underflow_d = 1'b1;
               end else if (head_sof == at_origin) begin
                  pop           = 1'b1;
                  rgb_d         = head_rgb;
                  frame_start_d = at_origin;
               end
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Registered outputs towards the encoders
   // ------------------------------------------------------------------

   // Timing outputs: one cycle behind the counter position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         draw_area <= 1'b0;
         hsync     <= 1'b0;
         vsync     <= 1'b0;
      end else begin
         draw_area <= act;
         hsync     <= hsync_d;
         vsync     <= vsync_d;
      end
   end

   // Pixel data and status pulses; blank unless a pixel is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red         <= 8'h00;
         green       <= 8'h00;
         blue        <= 8'h00;
         underflow   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         red         <= rgb_d[23:16];
         green       <= rgb_d[15:8];
         blue        <= rgb_d[7:0];
         underflow   <= underflow_d;
         frame_start <= frame_start_d;
      end
   end

endmodule

// File: tb/tb_hdmi_pixel_feeder.sv
// tb_hdmi_pixel_feeder
// Drives randomized pixel streams into a shrunken-timing hdmi_pixel_feeder
// and compares every output cycle against a frame-level reference model that
// derives the raster position arithmetically from the cycle number and keeps
// the buffered pixels in a queue.

module tb_hdmi_pixel_feeder;

   localparam int H_ACTIVE     = 4;
   localparam int H_TOTAL      = 8;
   localparam int H_SYNC_START = 5;
   localparam int H_SYNC_END   = 6;
   localparam int V_ACTIVE     = 2;
   localparam int V_TOTAL      = 4;
   localparam int V_SYNC_START = 2;
   localparam int V_SYNC_END   = 3;
   localparam int FIFO_AW      = 2;
   localparam int DEPTH        = 1 << FIFO_AW;
   localparam int W            = 29;

   localparam logic [1:0] M_SEEK = 2'd0;
   localparam logic [1:0] M_WAIT = 2'd1;
   localparam logic [1:0] M_RUN  = 2'd2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] s_data;
   logic        s_sof;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  red, green, blue;
   logic        draw_area, hsync, vsync, underflow, frame_start;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   hdmi_pixel_feeder #(
      .H_ACTIVE    (H_ACTIVE),
      .H_TOTAL     (H_TOTAL),
      .H_SYNC_START(H_SYNC_START),
      .H_SYNC_END  (H_SYNC_END),
      .V_ACTIVE    (V_ACTIVE),
      .V_TOTAL     (V_TOTAL),
      .V_SYNC_START(V_SYNC_START),
      .V_SYNC_END  (V_SYNC_END),
      .FIFO_AW     (FIFO_AW),
      .BLANK_RGB   (24'h000000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_data     (s_data),
      .s_sof      (s_sof),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .draw_area  (draw_area),
      .hsync      (hsync),
      .vsync      (vsync),
      .underflow  (underflow),
      .frame_start(frame_start),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard / model state ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [W-1:0] exp_q[$];   // {rgb, draw_area, hsync, vsync, underflow, frame_start}
   logic [24:0] m_q[$];      // pixels the model believes are buffered
   logic [24:0] src_q[$];    // pixels the source still has to deliver
   logic [1:0]  m_mode = M_SEEK;
   int          m_t = 0;     // cycles since reset release
   int          valid_pct = 100;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h at time %0t (model cycle %0d)",
                  tag, obs, exp, $time, m_t);
      end
   endtask

   // Reference model: one output cycle computed from the raster position.
   task automatic model_step(input logic push, input logic [24:0] word);
      int          h, v;
      logic        act, origin, hs, vs, uf, fs, pop;
      logic [23:0] rgb;
      logic [1:0]  nxt;
      h      = m_t % H_TOTAL;
      v      = (m_t / H_TOTAL) % V_TOTAL;
      act    = (h < H_ACTIVE) && (v < V_ACTIVE);
      origin = (h == 0) && (v == 0);
      hs     = (h >= H_SYNC_START) && (h < H_SYNC_END);
      vs     = (v >= V_SYNC_START) && (v < V_SYNC_END);
      rgb    = 24'h000000;
      uf     = 1'b0;
      fs     = 1'b0;
      pop    = 1'b0;
      nxt    = m_mode;
      if (m_mode == M_SEEK) begin
         if (m_q.size() > 0) begin
            if (m_q[0][24]) nxt = M_WAIT;
            else pop = 1'b1;
         end
      end else if (m_mode == M_WAIT) begin
         if (h == H_TOTAL - 1 && v == V_TOTAL - 1) nxt = M_RUN;
      end else if (act) begin
         if (m_q.size() == 0) begin
            uf  = 1'b1;
            nxt = M_SEEK;
         end else if (m_q[0][24] == origin) begin
            pop = 1'b1;
            rgb = m_q[0][23:0];
            fs  = origin;
         end else if (origin) begin
            nxt = M_SEEK;
         end else begin
            nxt = M_WAIT;
         end
      end
      exp_q.push_back({rgb, act, hs, vs, uf, fs});
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(word);
      m_mode = nxt;
      m_t++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      logic        push;
      logic        exp_ready;
      logic [24:0] word;
      logic [W-1:0] e;
      @(negedge clk);
      if (src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
         word    = src_q[0];
         s_valid = 1'b1;
      end else begin
         word    = {1'($urandom_range(0, 1)), 24'($urandom)};
         s_valid = 1'b0;
      end
      s_sof  = word[24];
      s_data = word[23:0];
      exp_ready = (m_t > 0) && (m_q.size() < DEPTH);
      check("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
      push = s_valid && exp_ready;
      if (push) void'(src_q.pop_front());
      model_step(push, word);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("exp_q_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("rgb", {8'h00, red, green, blue}, {8'h00, e[28:5]});
         check("ctrl(de,hs,vs,uf,fs)",
               {27'd0, draw_area, hsync, vsync, underflow, frame_start}, {27'd0, e[4:0]});
      end
      check("state", {30'd0, dbg_state}, {30'd0, m_mode});
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push_frame(input int len);
      for (int i = 0; i < len; i++) src_q.push_back({(i == 0), 24'(i + 1)});
   endtask

   task automatic push_garbage(input int n);
      for (int i = 0; i < n; i++) src_q.push_back({1'b0, 24'($urandom)});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rgb"}, {8'h00, red, green, blue}, 32'd0);
      check({tag, "_ctrl"}, {27'd0, draw_area, hsync, vsync, underflow, frame_start}, 32'd0);
      check({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
      check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, M_SEEK});
   endtask

   // Hold reset for some edges, checking outputs, then release mid-cycle.
   task automatic apply_reset(input int hold);
      rst     = 1'b1;
      s_valid = 1'b0;
      repeat (hold) begin
         @(posedge clk);
         #1;
         check_zero("rst_hold");
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      m_q.delete();
      src_q.delete();
      exp_q.delete();
      m_mode = M_SEEK;
      m_t    = 0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_data  = 24'h0;

      // Idle timing after reset, no source data.
      apply_reset(2);
      valid_pct = 100;
      run_cycles(40);

      // Continuous 8-pixel frames; FIFO fills and back-pressures.
      for (int f = 0; f < 4; f++) push_frame(8);
      run_cycles(200);

      // Source stalls after pixel 5, then resumes with aligned frames.
      push_frame(8);
      push_frame(5);
      run_cycles(100);
      for (int f = 0; f < 3; f++) push_frame(8);
      run_cycles(150);

      // Short (7-pixel) frame followed by correct frames.
      push_frame(7);
      for (int f = 0; f < 3; f++) push_frame(8);
      run_cycles(170);

      // Garbage ahead of the first sof after a fresh reset.
      apply_reset(1);
      push_garbage(5);
      for (int f = 0; f < 2; f++) push_frame(8);
      run_cycles(120);

      // Randomized frame lengths, garbage and source gaps.
      for (int r = 0; r < 8; r++) begin
         valid_pct = $urandom_range(40, 100);
         push_garbage($urandom_range(0, 2));
         for (int f = 0; f < 2; f++) push_frame($urandom_range(6, 9));
         run_cycles(90);
      end

      // Asynchronous reset in the middle of an active line.
      valid_pct = 100;
      push_frame(8);
      push_frame(8);
      run_cycles(43);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      apply_reset(2);
      for (int f = 0; f < 2; f++) push_frame(8);
      run_cycles(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
